// File: rtl/pwm_capture_if.sv
// pwm_capture_if
//  Bundles the PWM input line and the measurement results of pwm_capture.
//  Signals:
//    pwm_in        raw, asynchronous PWM line (driven by the environment)
//    width         high time of the last valid frame, clk cycles
//    period        rise-to-rise period of the last valid frame, clk cycles
//    sample_valid  1-cycle strobe: width/period/pos_char updated
//    frame_err     1-cycle strobe: frame rejected, period out of range
//    signal_lost   level: no edge seen for the timeout interval
//    pos_char      ASCII position code "I"/"P"/"E"/"T", or "?"
//    settled       level: width unchanged over several valid frames
//  Modports:
//    slave   the capture block (consumes pwm_in, produces results)
//    master  the environment (drives pwm_in, consumes results)
`timescale 1ns/1ps

interface pwm_capture_if #(
  parameter int CNT_W = 26
);
  logic             pwm_in;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] period;
  logic             sample_valid;
  logic             frame_err;
  logic             signal_lost;
  logic [7:0]       pos_char;
  logic             settled;

  modport slave (
    input  pwm_in,
    output width, period, sample_valid, frame_err, signal_lost, pos_char, settled
  );

  modport master (
    output pwm_in,
    input  width, period, sample_valid, frame_err, signal_lost, pos_char, settled
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture
//  Receive-side monitor for a 50 Hz servo PWM line. The raw line is
//  synchronised, its edges detected, and each rise-to-rise frame is measured
//  for high time and period. Frames with a period inside the accepted window
//  update the results and the servo position code; others raise frame_err.
//  A line with no edges for TIMEOUT_COUNT cycles is flagged as lost.
//  Ports:
//    clk    system clock (27 MHz nominal)
//    rst_n  asynchronous active-low reset, released synchronously by the system
//    bus    pwm_capture_if.slave: pwm_in in, measurement results out
`timescale 1ns/1ps

module pwm_capture #(
  parameter int CNT_W         = 26,
  parameter int MIN_PERIOD    = 530_000,
  parameter int MAX_PERIOD    = 550_000,
  parameter int TIMEOUT_COUNT = 1_080_000,
  parameter int TOL           = 150,
  parameter int IDLE_W        = 22_499,
  parameter int PRELOAD_W     = 30_499,
  parameter int DELIVERY_W    = 60_499,
  parameter int TOP_W         = 67_499,
  parameter int STABLE_FRAMES = 4
) (
  input logic           clk,
  input logic           rst_n,
  pwm_capture_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Constants, all sized to the counter width so comparisons are width-exact
  // ---------------------------------------------------------------------------
  localparam int STAB_W = $clog2(STABLE_FRAMES + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  MIN_X       = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]  MAX_X       = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0]  TMO_LAST    = CNT_W'(TIMEOUT_COUNT - 1);
  localparam logic [CNT_W-1:0]  IDLE_X      = CNT_W'(IDLE_W);
  localparam logic [CNT_W-1:0]  PRELOAD_X   = CNT_W'(PRELOAD_W);
  localparam logic [CNT_W-1:0]  DELIVERY_X  = CNT_W'(DELIVERY_W);
  localparam logic [CNT_W-1:0]  TOP_X       = CNT_W'(TOP_W);
  localparam logic [CNT_W:0]    TOL_X       = (CNT_W+1)'(TOL);
  localparam logic [STAB_W-1:0] STABLE_LAST = STAB_W'(STABLE_FRAMES - 1);

  localparam logic [7:0] CHAR_I    = 8'h49;  // "I" idle
  localparam logic [7:0] CHAR_P    = 8'h50;  // "P" preload
  localparam logic [7:0] CHAR_E    = 8'h45;  // "E" delivery
  localparam logic [7:0] CHAR_T    = 8'h54;  // "T" top
  localparam logic [7:0] CHAR_NONE = 8'h3F;  // "?" no match

  typedef enum logic [1:0] {
    ST_WAIT_RISE = 2'd0,
    ST_HIGH      = 2'd1,
    ST_LOW       = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Absolute difference taken one bit wider than the operands, so the larger
  // minus the smaller never underflows and no signed arithmetic is needed.
  function automatic logic near(input logic [CNT_W-1:0] w,
                                input logic [CNT_W-1:0] nom);
    logic [CNT_W:0] diff;
    diff = (w >= nom) ? ({1'b0, w} - {1'b0, nom}) : ({1'b0, nom} - {1'b0, w});
    return diff <= TOL_X;
  endfunction

  // First match wins, in idle / preload / delivery / top order.
  function automatic logic [7:0] classify(input logic [CNT_W-1:0] w);
    logic [7:0] c;
    c = CHAR_NONE;
    if      (near(w, IDLE_X))     c = CHAR_I;
    else if (near(w, PRELOAD_X))  c = CHAR_P;
    else if (near(w, DELIVERY_X)) c = CHAR_E;
    else if (near(w, TOP_X))      c = CHAR_T;
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        sync_q,        sync_d;
  logic              prev_q,        prev_d;
  logic [2:0]        prime_q,       prime_d;
  state_e            state_q,       state_d;
  logic [CNT_W-1:0]  hi_cnt_q,      hi_cnt_d;
  logic [CNT_W-1:0]  per_cnt_q,     per_cnt_d;
  logic [CNT_W-1:0]  width_tmp_q,   width_tmp_d;
  logic [CNT_W-1:0]  edge_idle_q,   edge_idle_d;
  logic [CNT_W-1:0]  width_q,       width_d;
  logic [CNT_W-1:0]  period_q,      period_d;
  logic              sample_valid_q, sample_valid_d;
  logic              frame_err_q,   frame_err_d;
  logic              signal_lost_q, signal_lost_d;
  logic [7:0]        pos_char_q,    pos_char_d;
  logic [STAB_W-1:0] stable_cnt_q,  stable_cnt_d;
  logic              settled_q,     settled_d;

  logic edges_on;
  logic rise;
  logic fall;
  logic any_edge;
  logic timeout;
  logic frame_ok;

  // The synchroniser and edge register come out of reset at 0. If the line is
  // already high at release, sync_q[1] rises before prev_q has caught up and
  // would look like a rising edge mid-frame. prime_q holds edge detection off
  // until prev_q reflects the pin, so a frame cut by reset is simply dropped.
  assign edges_on = prime_q[2];
  assign rise     = edges_on &  sync_q[1] & ~prev_q;
  assign fall     = edges_on & ~sync_q[1] &  prev_q;
  assign any_edge = rise | fall;

  // An edge in the same cycle as the timeout threshold wins.
  assign timeout  = ~any_edge && (edge_idle_q == TMO_LAST);

  // A saturated period counter is rejected even if MAX_PERIOD is all-ones.
  assign frame_ok = (per_cnt_q >= MIN_X) && (per_cnt_q <= MAX_X) && (per_cnt_q != CNT_MAX);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every _d gets a default before any branch, so no path can leave a
  // variable unassigned and infer a latch.
  always_comb begin
    sync_d         = {sync_q[0], bus.pwm_in};
    prev_d         = sync_q[1];
    prime_d        = {prime_q[1:0], 1'b1};
    state_d        = state_q;
    hi_cnt_d       = hi_cnt_q;
    per_cnt_d      = per_cnt_q;
    width_tmp_d    = width_tmp_q;
    edge_idle_d    = any_edge ? '0 : sat_inc(edge_idle_q);
    width_d        = width_q;
    period_d       = period_q;
    sample_valid_d = 1'b0;
    frame_err_d    = 1'b0;
    signal_lost_d  = signal_lost_q;
    pos_char_d     = pos_char_q;
    stable_cnt_d   = stable_cnt_q;

    unique case (state_q)
      ST_WAIT_RISE: begin
        // The first rise only arms measurement; there is no frame to close.
        hi_cnt_d  = '0;
        per_cnt_d = '0;
        if (rise) begin
          state_d   = ST_HIGH;
          hi_cnt_d  = CNT_W'(1);
          per_cnt_d = CNT_W'(1);
        end
      end

      ST_HIGH: begin
        hi_cnt_d  = sat_inc(hi_cnt_q);
        per_cnt_d = sat_inc(per_cnt_q);
        if (fall) begin
          state_d     = ST_LOW;
          width_tmp_d = hi_cnt_q;
        end
      end

      ST_LOW: begin
        per_cnt_d = sat_inc(per_cnt_q);
        if (rise) begin
          if (frame_ok) begin
            width_d        = width_tmp_q;
            period_d       = per_cnt_q;
            pos_char_d     = classify(width_tmp_q);
            sample_valid_d = 1'b1;
            signal_lost_d  = 1'b0;
            if (width_tmp_q != width_q)
              stable_cnt_d = '0;
            else if (stable_cnt_q < STABLE_LAST)
              stable_cnt_d = stable_cnt_q + 1'b1;
          end else begin
            frame_err_d  = 1'b1;
            stable_cnt_d = '0;
          end
          // This rise also opens the next frame, so back-to-back frames
          // lose no cycle.
          state_d   = ST_HIGH;
          hi_cnt_d  = CNT_W'(1);
          per_cnt_d = CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_WAIT_RISE;
        hi_cnt_d  = '0;
        per_cnt_d = '0;
      end
    endcase

    // Line stuck high or low: abandon the frame silently and re-arm.
    if (timeout) begin
      signal_lost_d = 1'b1;
      stable_cnt_d  = '0;
      pos_char_d    = CHAR_NONE;
      state_d       = ST_WAIT_RISE;
      hi_cnt_d      = '0;
      per_cnt_d     = '0;
    end

    // Derived from the next count so settled drops in the same cycle the
    // differing width is presented.
    settled_d = (stable_cnt_d >= STABLE_LAST);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q         <= '0;
      prev_q         <= 1'b0;
      prime_q        <= '0;
      state_q        <= ST_WAIT_RISE;
      hi_cnt_q       <= '0;
      per_cnt_q      <= '0;
      width_tmp_q    <= '0;
      edge_idle_q    <= '0;
      width_q        <= '0;
      period_q       <= '0;
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      signal_lost_q  <= 1'b1;
      pos_char_q     <= CHAR_NONE;
      stable_cnt_q   <= '0;
      settled_q      <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      prev_q         <= prev_d;
      prime_q        <= prime_d;
      state_q        <= state_d;
      hi_cnt_q       <= hi_cnt_d;
      per_cnt_q      <= per_cnt_d;
      width_tmp_q    <= width_tmp_d;
      edge_idle_q    <= edge_idle_d;
      width_q        <= width_d;
      period_q       <= period_d;
      sample_valid_q <= sample_valid_d;
      frame_err_q    <= frame_err_d;
      signal_lost_q  <= signal_lost_d;
      pos_char_q     <= pos_char_d;
      stable_cnt_q   <= stable_cnt_d;
      settled_q      <= settled_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all straight from flops
  // ---------------------------------------------------------------------------
  assign bus.width        = width_q;
  assign bus.period       = period_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.signal_lost  = signal_lost_q;
  assign bus.pos_char     = pos_char_q;
  assign bus.settled      = settled_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
//  Self-checking bench for pwm_capture, run with frame timing scaled down so a
//  full sequence of frames fits in a short simulation. Each rise driven onto
//  the line closes the previous frame; the bench model works out the expected
//  strobe and result values for that frame and queues them. A monitor pops
//  and compares on every sample_valid / frame_err strobe. Scenario tasks add
//  direct level checks on the outputs between frames.
`timescale 1ns/1ps

module tb_pwm_capture;

  localparam int CNT_W         = 16;
  localparam int MIN_PERIOD    = 1060;
  localparam int MAX_PERIOD    = 1100;
  localparam int NOM_PERIOD    = 1080;
  localparam int TIMEOUT_COUNT = 1500;
  localparam int TOL           = 15;
  localparam int IDLE_W        = 224;
  localparam int PRELOAD_W     = 304;
  localparam int DELIVERY_W    = 604;
  localparam int TOP_W         = 674;
  localparam int STABLE_FRAMES = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(
    .CNT_W(CNT_W), .MIN_PERIOD(MIN_PERIOD), .MAX_PERIOD(MAX_PERIOD),
    .TIMEOUT_COUNT(TIMEOUT_COUNT), .TOL(TOL), .IDLE_W(IDLE_W),
    .PRELOAD_W(PRELOAD_W), .DELIVERY_W(DELIVERY_W), .TOP_W(TOP_W),
    .STABLE_FRAMES(STABLE_FRAMES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit               is_err;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] period;
    logic [7:0]       pos;
    bit               settled;
    bit               lost;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;

  // Reference model of the measured line.
  bit         m_armed;
  int         m_cur_h, m_cur_p;
  int         m_width, m_period;
  logic [7:0] m_pos;
  int         m_stable;
  bit         m_lost;

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic logic [7:0] ref_class(int w);
    if (iabs(w - IDLE_W)     <= TOL) return "I";
    if (iabs(w - PRELOAD_W)  <= TOL) return "P";
    if (iabs(w - DELIVERY_W) <= TOL) return "E";
    if (iabs(w - TOP_W)      <= TOL) return "T";
    return "?";
  endfunction

  function automatic void model_reset();
    m_armed = 0; m_width = 0; m_period = 0; m_pos = "?"; m_stable = 0; m_lost = 1;
  endfunction

  function automatic void model_timeout();
    m_armed = 0; m_pos = "?"; m_stable = 0; m_lost = 1;
  endfunction

  // A rise on the line: closes the open frame (if any) and opens a new one.
  function automatic void model_rise(int h, int p);
    exp_t e;
    if (m_armed) begin
      if (m_cur_p >= MIN_PERIOD && m_cur_p <= MAX_PERIOD) begin
        m_stable = (m_cur_h == m_width) ? ((m_stable < STABLE_FRAMES - 1) ? m_stable + 1 : m_stable) : 0;
        m_width  = m_cur_h;
        m_period = m_cur_p;
        m_pos    = ref_class(m_cur_h);
        m_lost   = 0;
        e.is_err = 0;
      end else begin
        m_stable = 0;
        e.is_err = 1;
      end
      e.width   = CNT_W'(m_width);
      e.period  = CNT_W'(m_period);
      e.pos     = m_pos;
      e.settled = (m_stable >= STABLE_FRAMES - 1);
      e.lost    = m_lost;
      sb.push_back(e);
    end
    m_armed = 1;
    m_cur_h = h;
    m_cur_p = p;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: every strobe must match the oldest queued expectation
  // ---------------------------------------------------------------------------
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && (bus.sample_valid || bus.frame_err)) begin
      if (bus.sample_valid) n_valid++;
      if (bus.frame_err)    n_err++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected @%0t: sample_valid=%0b frame_err=%0b width=%0d period=%0d, required no strobe",
                 $time, bus.sample_valid, bus.frame_err, bus.width, bus.period);
      end else begin
        mon_e = sb.pop_front();
        n_checks++;
        if (bus.frame_err !== mon_e.is_err || bus.sample_valid !== !mon_e.is_err) begin
          n_fail++;
          $display("FAIL strobe_kind @%0t: sample_valid=%0b frame_err=%0b, required sample_valid=%0b frame_err=%0b",
                   $time, bus.sample_valid, bus.frame_err, !mon_e.is_err, mon_e.is_err);
        end
        n_checks++;
        if (bus.width !== mon_e.width) begin
          n_fail++;
          $display("FAIL strobe_width @%0t: got %0d, required %0d", $time, bus.width, mon_e.width);
        end
        n_checks++;
        if (bus.period !== mon_e.period) begin
          n_fail++;
          $display("FAIL strobe_period @%0t: got %0d, required %0d", $time, bus.period, mon_e.period);
        end
        n_checks++;
        if (bus.pos_char !== mon_e.pos) begin
          n_fail++;
          $display("FAIL strobe_pos_char @%0t: got %c, required %c", $time, bus.pos_char, mon_e.pos);
        end
        n_checks++;
        if (bus.settled !== mon_e.settled) begin
          n_fail++;
          $display("FAIL strobe_settled @%0t: got %0b, required %0b", $time, bus.settled, mon_e.settled);
        end
        n_checks++;
        if (bus.signal_lost !== mon_e.lost) begin
          n_fail++;
          $display("FAIL strobe_signal_lost @%0t: got %0b, required %0b", $time, bus.signal_lost, mon_e.lost);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all start and end 1 time unit after a rising clk edge)
  // ---------------------------------------------------------------------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(int h, int p);
    model_rise(h, p);
    bus.pwm_in = 1'b1;
    tick(h);
    bus.pwm_in = 1'b0;
    tick(p - h);
  endtask

  task automatic wait_drain(string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: %0d expected strobes still pending, required 0", tag, sb.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  logic [2*CNT_W+11:0] got_v, req_v;

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.pwm_in = 1'b0;
    tick(3);
    got_v = {bus.width, bus.period, bus.sample_valid, bus.frame_err, bus.signal_lost, bus.pos_char, bus.settled};
    req_v = {CNT_W'(0), CNT_W'(0), 1'b0, 1'b0, 1'b1, 8'h3F, 1'b0};
    n_checks++;
    if (got_v !== req_v) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required %h (width,period,sv,fe,lost,pos,settled)", got_v, req_v);
    end
    rst_n = 1'b1;
    model_reset();
    tick(5);
  endtask

  task automatic test_basic();
    int v0;
    v0 = n_valid;
    repeat (3) drive_frame(IDLE_W + 1, NOM_PERIOD);
    n_checks++;
    if (n_valid - v0 != 2) begin
      n_fail++;
      $display("FAIL basic_valid_count: got %0d, required 2", n_valid - v0);
    end
    n_checks++;
    if (bus.width !== CNT_W'(IDLE_W + 1) || bus.pos_char !== "I") begin
      n_fail++;
      $display("FAIL basic_result: width=%0d pos=%c, required width=%0d pos=I", bus.width, bus.pos_char, IDLE_W + 1);
    end
    wait_drain("basic");
  endtask

  task automatic test_width_step();
    for (int w = PRELOAD_W + 1; w <= DELIVERY_W + 1; w += 50) drive_frame(w, NOM_PERIOD);
    repeat (4) drive_frame(DELIVERY_W + 1, NOM_PERIOD);
    n_checks++;
    if (bus.settled !== 1'b1 || bus.pos_char !== "E") begin
      n_fail++;
      $display("FAIL step_final: settled=%0b pos=%c, required settled=1 pos=E", bus.settled, bus.pos_char);
    end
    wait_drain("step");
  endtask

  task automatic test_frame_err();
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    drive_frame(DELIVERY_W + 1, 800);
    drive_frame(DELIVERY_W + 1, 1300);
    drive_frame(DELIVERY_W + 1, NOM_PERIOD);
    n_checks++;
    if (n_err - e0 != 2 || n_valid - v0 != 1) begin
      n_fail++;
      $display("FAIL err_counts: frame_err=%0d sample_valid=%0d, required 2 and 1", n_err - e0, n_valid - v0);
    end
    n_checks++;
    if (bus.width !== CNT_W'(DELIVERY_W + 1) || bus.period !== CNT_W'(NOM_PERIOD) || bus.settled !== 1'b0) begin
      n_fail++;
      $display("FAIL err_hold: width=%0d period=%0d settled=%0b, required %0d %0d 0",
               bus.width, bus.period, bus.settled, DELIVERY_W + 1, NOM_PERIOD);
    end
    wait_drain("frame_err");
  endtask

  task automatic test_boundaries();
    int hs[8];
    int ps[8];
    hs = '{TOP_W + TOL, TOP_W + TOL + 1, IDLE_W - TOL, IDLE_W - TOL, IDLE_W - TOL,
           IDLE_W - TOL, IDLE_W - TOL, IDLE_W + 1};
    ps = '{NOM_PERIOD, NOM_PERIOD, NOM_PERIOD, MIN_PERIOD, MAX_PERIOD,
           MIN_PERIOD - 1, MAX_PERIOD + 1, NOM_PERIOD};
    for (int i = 0; i < 8; i++) drive_frame(hs[i], ps[i]);
    wait_drain("boundaries");
  endtask

  task automatic test_timeout();
    int e0;
    e0 = n_err;
    model_rise(0, 0);
    bus.pwm_in = 1'b1;
    tick(TIMEOUT_COUNT + 100);
    n_checks++;
    if (bus.signal_lost !== 1'b1 || bus.pos_char !== "?" || bus.settled !== 1'b0 || n_err != e0) begin
      n_fail++;
      $display("FAIL timeout_flags: lost=%0b pos=%c settled=%0b frame_errs=%0d, required 1 ? 0 0",
               bus.signal_lost, bus.pos_char, bus.settled, n_err - e0);
    end
    model_timeout();
    bus.pwm_in = 1'b0;
    tick(50);
    drive_frame(IDLE_W + 1, NOM_PERIOD);
    n_checks++;
    if (bus.signal_lost !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_arm_only: lost=%0b, required 1", bus.signal_lost);
    end
    repeat (2) drive_frame(IDLE_W + 1, NOM_PERIOD);
    n_checks++;
    if (bus.signal_lost !== 1'b0 || bus.width !== CNT_W'(IDLE_W + 1) || bus.pos_char !== "I") begin
      n_fail++;
      $display("FAIL timeout_recover: lost=%0b width=%0d pos=%c, required 0 %0d I",
               bus.signal_lost, bus.width, bus.pos_char, IDLE_W + 1);
    end
    wait_drain("timeout");
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    model_rise(IDLE_W + 1, NOM_PERIOD);
    bus.pwm_in = 1'b1;
    tick(100);
    rst_n = 1'b0;
    tick(2);
    got_v = {bus.width, bus.period, bus.sample_valid, bus.frame_err, bus.signal_lost, bus.pos_char, bus.settled};
    req_v = {CNT_W'(0), CNT_W'(0), 1'b0, 1'b0, 1'b1, 8'h3F, 1'b0};
    n_checks++;
    if (got_v !== req_v) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h, required %h (width,period,sv,fe,lost,pos,settled)", got_v, req_v);
    end
    rst_n = 1'b1;
    model_reset();
    v0 = n_valid;
    e0 = n_err;
    tick(125);
    bus.pwm_in = 1'b0;
    tick(500);
    repeat (3) drive_frame(IDLE_W + 1, NOM_PERIOD);
    n_checks++;
    if (n_valid - v0 != 2 || n_err != e0 || bus.width !== CNT_W'(IDLE_W + 1) || bus.period !== CNT_W'(NOM_PERIOD)) begin
      n_fail++;
      $display("FAIL midreset_recover: valids=%0d errs=%0d width=%0d period=%0d, required 2 0 %0d %0d",
               n_valid - v0, n_err - e0, bus.width, bus.period, IDLE_W + 1, NOM_PERIOD);
    end
    wait_drain("midreset");
  endtask

  initial begin
    bus.pwm_in = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_width_step();
    test_frame_err();
    test_boundaries();
    test_timeout();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
